// File: rtl/mic_axis_frame_fifo.sv
// Frame-aligned 2-beat AXIS FIFO: beats held tentatively until beat1 commits; malformed frames rolled back.
// Output is FWFT one cycle after commit; upstream stalls only when full. Counters exist when MIC_FIFO_STATS_EN is defined.
module mic_axis_frame_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             sck,
  input  logic             rst,
  input  logic             flush,
  input  logic [127:0]     s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [127:0]     m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {BEAT0, BEAT1, DISCARD} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   wr_ptr, cm_ptr, rd_ptr;
  logic [128:0]    mem [DEPTH];
  logic            full, avail, s_acc, m_acc;
  logic            wr_en, commit, rollback, err_ev;

  assign full          = (wr_ptr - rd_ptr) == PW'(DEPTH);
  assign avail         = cm_ptr != rd_ptr;
  assign s_axis_tready = !rst && (state == DISCARD || !full);
  assign s_acc         = s_axis_tvalid && s_axis_tready;
  assign m_acc         = avail && m_axis_tready;
  assign m_axis_tvalid = avail;
  // Gate the head entry so idle/reset output is all zeros rather than stale memory.
  assign {m_axis_tlast, m_axis_tdata} = avail ? mem[rd_ptr[AW-1:0]] : '0;

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    commit    = 1'b0;
    rollback  = 1'b0;
    err_ev    = 1'b0;
    if (s_acc) begin
      case (state)
        BEAT0: begin
          if (s_axis_tlast) begin
            err_ev = 1'b1;
          end else begin
            wr_en     = 1'b1;
            state_nxt = BEAT1;
          end
        end
        BEAT1: begin
          if (s_axis_tlast) begin
            wr_en     = 1'b1;
            commit    = 1'b1;
            state_nxt = BEAT0;
          end else begin
            rollback  = 1'b1;
            err_ev    = 1'b1;
            state_nxt = DISCARD;
          end
        end
        DISCARD: begin
          if (s_axis_tlast) state_nxt = BEAT0;
        end
        default: state_nxt = BEAT0;
      endcase
    end
    // Flush drops the beat of this cycle; realign on the next frame boundary.
    if (flush) begin
      wr_en     = 1'b0;
      commit    = 1'b0;
      rollback  = 1'b0;
      err_ev    = 1'b0;
      state_nxt = ((state == BEAT0 && !s_acc) || (s_acc && s_axis_tlast)) ? BEAT0 : DISCARD;
    end
  end

  always_ff @(posedge sck) begin
    if (rst) begin
      state     <= BEAT0;
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      rd_ptr    <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_err <= err_ev;
      if (flush) begin
        wr_ptr <= '0;
        cm_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en)    wr_ptr <= wr_ptr + 1'b1;
        if (rollback) wr_ptr <= cm_ptr;
        if (commit)   cm_ptr <= wr_ptr + 1'b1;
        if (m_acc)    rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge sck) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

`ifdef MIC_FIFO_STATS_EN
  logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;

  always_ff @(posedge sck) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (commit && frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (err_ev && err_cnt_q != '1)   err_cnt_q   <= err_cnt_q + 1'b1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_mic_axis_frame_fifo.sv
// Bench for mic_axis_frame_fifo: queue-based frame model checked every cycle, directed scenarios plus random traffic.
module tb_mic_axis_frame_fifo;
  localparam int DEPTH = 16;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef MIC_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             sck = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [127:0]     s_axis_tdata = '0;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tlast = 1'b0;
  logic             s_axis_tready;
  logic [127:0]     m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tready = 1'b0;
  logic             frame_err;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;

  mic_axis_frame_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .sck(sck), .rst(rst), .flush(flush),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .frame_err(frame_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 sck = ~sck;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: committed-unread beats, tentatively held beat0, discard flag.
  logic [128:0] mq[$];
  logic [128:0] pq[$];
  bit           disc = 1'b0;
  bit           merr = 1'b0;
  int           fcnt = 0;
  int           ecnt = 0;
  bit           mon_en = 1'b0;
  logic [128:0] out_log[$];
  int           err_pulses = 0;

  always @(negedge sck) begin : mon
    bit           rdy, acc, rd, errn, b0;
    logic [128:0] head;
    if (mon_en) begin
      rdy  = !rst && (disc || (mq.size() + pq.size() < DEPTH));
      head = (mq.size() != 0) ? mq[0] : '0;
      chk("m_tvalid", m_axis_tvalid, mq.size() != 0);
      chk("m_tdata", m_axis_tdata, head[127:0]);
      chk("m_tlast", m_axis_tlast, head[128]);
      chk("s_tready", s_axis_tready, rdy);
      chk("frame_err", frame_err, merr);
      chk("frame_cnt", frame_cnt, STATS ? fcnt : 0);
      chk("err_cnt", err_cnt, STATS ? ecnt : 0);
      if (m_axis_tvalid && m_axis_tready) out_log.push_back({m_axis_tlast, m_axis_tdata});
      if (frame_err) err_pulses++;

      acc  = s_axis_tvalid && rdy;
      rd   = (mq.size() != 0) && m_axis_tready;
      errn = 1'b0;
      if (rst) begin
        mq.delete(); pq.delete(); disc = 1'b0; fcnt = 0; ecnt = 0;
      end else if (flush) begin
        b0   = !disc && pq.size() == 0;
        disc = !((b0 && !acc) || (acc && s_axis_tlast));
        mq.delete(); pq.delete();
      end else begin
        if (rd) void'(mq.pop_front());
        if (acc) begin
          if (disc) begin
            if (s_axis_tlast) disc = 1'b0;
          end else if (pq.size() == 0) begin
            if (s_axis_tlast) errn = 1'b1;
            else pq.push_back({1'b0, s_axis_tdata});
          end else if (s_axis_tlast) begin
            mq.push_back(pq[0]);
            mq.push_back({1'b1, s_axis_tdata});
            pq.delete();
            if (fcnt != CMAX) fcnt++;
          end else begin
            pq.delete();
            errn = 1'b1;
            disc = 1'b1;
          end
        end
        if (errn && ecnt != CMAX) ecnt++;
      end
      merr = errn;
    end
  end

  function automatic logic [127:0] bd(input int t);
    return {4{t ^ 32'hA5A5_0000}};
  endfunction

  task automatic tick();
    @(posedge sck); #1;
  endtask

  task automatic send(input logic [127:0] d, input logic l);
    bit done = 1'b0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge sck);
      done = s_axis_tready;
      tick();
    end
    s_axis_tvalid = 1'b0;
    chk("send_accept", done, 1'b1);
  endtask

  task automatic wait_log(input int n);
    int k = 0;
    while (out_log.size() < n && k < 300) begin
      tick();
      k++;
    end
    chk("drain_count", out_log.size(), n);
  endtask

  task automatic do_reset();
    rst = 1'b1; s_axis_tvalid = 1'b0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    out_log.delete();
    err_pulses = 0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit bn, acc;
    tick();
    mon_en = 1'b1;
    @(negedge sck);
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tdata", m_axis_tdata, 128'h0);
    tick();

    // 1: two good frames, FWFT latency
    do_reset();
    m_axis_tready = 1'b1;
    @(negedge sck); chk("t1_tready_idle", s_axis_tready, 1'b1); tick();
    send(bd(1), 1'b0);
    @(negedge sck); chk("t1_hidden_beat0", m_axis_tvalid, 1'b0); tick();
    send(bd(2), 1'b1);
    @(negedge sck);
    chk("t1_valid_after_commit", m_axis_tvalid, 1'b1);
    chk("t1_head", m_axis_tdata, bd(1));
    tick();
    send(bd(3), 1'b0);
    send(bd(4), 1'b1);
    wait_log(4);
    chk("t1_b0", out_log[0], {1'b0, bd(1)});
    chk("t1_b1", out_log[1], {1'b1, bd(2)});
    chk("t1_b2", out_log[2], {1'b0, bd(3)});
    chk("t1_b3", out_log[3], {1'b1, bd(4)});

    // 2: fill to DEPTH, stall, then release
    do_reset();
    m_axis_tready = 1'b0;
    for (int f = 0; f < 8; f++) begin
      send(bd(100 + 2*f), 1'b0);
      send(bd(101 + 2*f), 1'b1);
    end
    @(negedge sck); chk("t2_full_stall", s_axis_tready, 1'b0); tick();
    m_axis_tready = 1'b1;
    send(bd(116), 1'b0);
    send(bd(117), 1'b1);
    wait_log(18);
    for (int i = 0; i < 18; i++) chk("t2_order", out_log[i], {i[0], bd(100 + i)});

    // 3: bad beat1 then discard until tlast, then good frame C
    do_reset();
    send(bd(200), 1'b0);
    send(bd(201), 1'b0);
    send(bd(202), 1'b0);
    send(bd(203), 1'b0);
    send(bd(204), 1'b1);
    send(bd(205), 1'b0);
    send(bd(206), 1'b1);
    wait_log(2);
    repeat (4) tick();
    chk("t3_only_c", out_log.size(), 2);
    chk("t3_c0", out_log[0], {1'b0, bd(205)});
    chk("t3_c1", out_log[1], {1'b1, bd(206)});
    chk("t3_err_pulses", err_pulses, 1);
    chk("t3_err_cnt", err_cnt, STATS ? 1 : 0);

    // 4: lone tlast beat in BEAT0
    do_reset();
    send(bd(300), 1'b1);
    repeat (2) tick();
    @(negedge sck);
    chk("t4_err_pulses", err_pulses, 1);
    chk("t4_nothing_written", m_axis_tvalid, 1'b0);
    tick();
    send(bd(301), 1'b0);
    send(bd(302), 1'b1);
    wait_log(2);
    chk("t4_g0", out_log[0], {1'b0, bd(301)});
    chk("t4_g1", out_log[1], {1'b1, bd(302)});

    // 5: flush mid-frame with one committed frame
    do_reset();
    m_axis_tready = 1'b0;
    send(bd(400), 1'b0);
    send(bd(401), 1'b1);
    send(bd(402), 1'b0);
    @(negedge sck);
    chk("t5_prior_visible", m_axis_tvalid, 1'b1);
    chk("t5_prior_head", m_axis_tdata, bd(400));
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge sck); chk("t5_flushed", m_axis_tvalid, 1'b0); tick();
    send(bd(403), 1'b1);
    m_axis_tready = 1'b1;
    send(bd(404), 1'b0);
    send(bd(405), 1'b1);
    wait_log(2);
    repeat (4) tick();
    chk("t5_only_e", out_log.size(), 2);
    chk("t5_e0", out_log[0], {1'b0, bd(404)});
    chk("t5_e1", out_log[1], {1'b1, bd(405)});
    chk("t5_no_err", err_pulses, 0);

    // 6: counter saturation
    do_reset();
    for (int f = 0; f < CMAX + 4; f++) begin
      send(bd(500 + f), 1'b0);
      send(bd(600 + f), 1'b1);
    end
    repeat (3) tick();
    @(negedge sck);
    chk("t6_frame_cnt_sat", frame_cnt, STATS ? CMAX : 0);
    chk("t6_err_cnt", err_cnt, 0);
    tick();

    // random traffic with occasional errors, flushes and resets
    do_reset();
    bn = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tlast  = bn ^ ($urandom_range(0, 19) == 0);
      s_axis_tdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
      m_axis_tready = ((c / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      flush         = ($urandom_range(0, 149) == 0);
      rst           = ($urandom_range(0, 599) == 0);
      @(negedge sck);
      acc = s_axis_tvalid && s_axis_tready;
      tick();
      if (rst || flush) bn = 1'b0;
      else if (acc) bn = ~s_axis_tlast;
    end
    s_axis_tvalid = 1'b0; flush = 1'b0; rst = 1'b0; m_axis_tready = 1'b1;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
